mem_initiator: RTL
==================

// Module: mem_initiator
// PURPOSE
//  CPU-side initiator for the 16-bit read/write/resp memory interface. Accepts one word or byte
//  load/store from the datapath, drives mem_read/mem_write/byte_enable until the memory pulses
//  mem_resp, steers byte lanes (LDB/STB), returns read data, and aborts hung accesses on timeout.
//  Sits between the control FSM/datapath and the memory model.
// PARAMETERS
//  TIMEOUT_CYCLES  4095  cycles in BUSY without mem_resp before abort; 0 disables timeout
// PORTS
//  clk            in   1   clock; all state changes on rising edge
//  rst            in   1   asynchronous, active-high reset
//  req_read       in   1   load request (sampled only when req_ready=1)
//  req_write      in   1   store request (wins over req_read if both high)
//  req_byte       in   1   1=byte access, 0=word access
//  req_addr       in   16  byte address
//  req_wdata      in   16  store data; byte store uses [7:0]
//  req_ready      out  1   1 in IDLE only: request accepted on this edge
//  done           out  1   1-cycle pulse: access finished (ok or timeout)
//  err            out  1   1-cycle pulse coincident with done on timeout abort
//  rdata_out      out  16  load result, valid while done=1, held until next done
//  mem_read       out  1   to memory; registered
//  mem_write      out  1   to memory; registered
//  mem_byte_enable out 2   to memory; registered
//  mem_address    out  16  to memory; registered
//  mem_wdata      out  16  to memory; registered
//  mem_resp       in   1   from memory; 1-cycle pulse
//  mem_rdata      in   16  from memory; valid while mem_resp=1
// BEHAVIOUR
//  Reset (async, immediate): state IDLE, timeout counter 0; req_ready=1, all other outputs 0.
//  FSM states: IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: req_ready=1. On edge with req_read|req_write: latch request, drive mem_* after edge, go BUSY.
//   BUSY: mem_read/mem_write held stable; counter increments each cycle. Edge with mem_resp=1:
//         capture steered rdata, deassert mem_read/mem_write at that same edge, go DONE.
//         Edge with counter==TIMEOUT_CYCLES-1 and no mem_resp: deassert, set err, go DONE.
//         mem_resp and timeout on same edge: mem_resp wins, err=0.
//   DONE: done=1 (err per above) for exactly one cycle, req_ready=0; then IDLE.
//  Deassertion is mandatory on the edge mem_resp is sampled: memory returns to idle one cycle after
//  resp and would otherwise start a duplicate access.
//  mem_resp while IDLE or DONE (late response after abort): ignored, no output change.
//  Lane steering: word: mem_address={addr[15:1],0}, byte_enable=2'b11, mem_wdata=req_wdata.
//   byte: mem_address={addr[15:1],0}, byte_enable=addr[0]?2'b10:2'b01, mem_wdata={wdata[7:0],wdata[7:0]}.
//   Load result: word -> mem_rdata; byte -> {8'h00, addr[0]?mem_rdata[15:8]:mem_rdata[7:0]}.
//  Odd address on word access: bit 0 dropped silently, no error.
//  Latency: accept edge E; mem_* valid after E; resp sampled at edge R; done high cycle after R.
//  Minimum accept-to-accept spacing: 3 edges plus memory latency.
//  mem_byte_enable and mem_wdata for reads: byte_enable as steered, mem_wdata=0.
//  Counter width $clog2(TIMEOUT_CYCLES+1); saturates, never wraps.
//  rst asserted in BUSY: access abandoned, no done pulse; late mem_resp after release ignored.
// STRUCTURE
//  Package mem_if_pkg: state enum {IDLE,BUSY,DONE}, BE_WORD=2'b11, BE_LO=2'b01, BE_HI=2'b10.
//  Sub-module mem_byte_steer (combinational): address/byte_enable/wdata out-steering and rdata
//  in-steering; instantiated once. FSM, counter and output registers live in this module.
// TESTING
//  Word load 0x1235, memory holds 0x5678 at 0x1234 -> mem_address=0x1234, be=11, done with rdata_out=0x5678.
//  Byte store 0xAB to 0x0101 -> be=10, mem_wdata=0xABAB; readback word 0x0100 shows [15:8]=0xAB only.
//  Byte load from 0x0101 with word 0xAB34 -> rdata_out=0x00AB; from 0x0100 -> 0x0034.
//  TIMEOUT_CYCLES=8, memory never responds -> done&err in 9th cycle after accept; late resp ignored.
//  rst pulse mid-BUSY -> mem_read drops asynchronously, no done; next request completes normally.
//  Back-to-back read then write with req_read&req_write both high -> write issued; each access sees
//  exactly one mem_resp and mem_read/mem_write low for >=1 cycle between accesses.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared types for the CPU-side memory initiator: FSM states and byte-enable codes.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

  // Byte enable for an access of the given width at the given lane (address bit 0).
  function automatic logic [1:0] lane_be(input logic is_byte, input logic lane);
    if (!is_byte) return BE_WORD;
    return lane ? BE_HI : BE_LO;
  endfunction

endpackage

// File: rtl/mem_byte_steer.sv
// Combinational byte-lane steering: request -> memory lanes, memory read word -> load result.
import mem_if_pkg::*;

module mem_byte_steer (
  input  logic        req_write_i,
  input  logic        req_byte_i,
  input  logic [15:0] req_addr_i,
  input  logic [15:0] req_wdata_i,
  input  logic        lat_byte_i,
  input  logic        lat_lane_i,
  input  logic [15:0] mem_rdata_i,
  output logic [15:0] mem_address_o,
  output logic [1:0]  mem_be_o,
  output logic [15:0] mem_wdata_o,
  output logic [15:0] rdata_o
);

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    mem_address_o = {req_addr_i[15:1], 1'b0};
    mem_be_o      = lane_be(req_byte_i, req_addr_i[0]);
    mem_wdata_o   = '0;
    if (req_write_i) begin
      mem_wdata_o = req_byte_i ? {req_wdata_i[7:0], req_wdata_i[7:0]} : req_wdata_i;
    end
  end

  // Load result uses the lane latched at accept time, not the live request inputs.
  always_comb begin
    rdata_o = mem_rdata_i;
    if (lat_byte_i) begin
      rdata_o = {8'h00, lat_lane_i ? mem_rdata_i[15:8] : mem_rdata_i[7:0]};
    end
  end

endmodule

// File: rtl/mem_initiator.sv
// Single-outstanding load/store initiator for the 16-bit read/write/resp memory interface,
// with byte-lane steering and a saturating timeout that aborts hung accesses.
import mem_if_pkg::*;

module mem_initiator #(
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_read,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        done,
  output logic        err,
  output logic [15:0] rdata_out,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_byte_enable,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata
);

  localparam bit             TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam int             CW         = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0]  CNT_LAST   = CW'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0]  CNT_MAX    = {CW{1'b1}};

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          req_ready_q, done_q, err_q;
  logic [15:0]   rdata_q;
  logic          mem_read_q, mem_write_q;
  logic [1:0]    mem_be_q;
  logic [15:0]   mem_address_q, mem_wdata_q;
  logic          lat_byte_q, lat_lane_q;

  logic [15:0]   steer_address_d, steer_wdata_d, steer_rdata_d;
  logic [1:0]    steer_be_d;

  mem_byte_steer u_steer (
    .req_write_i   (req_write),
    .req_byte_i    (req_byte),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .lat_byte_i    (lat_byte_q),
    .lat_lane_i    (lat_lane_q),
    .mem_rdata_i   (mem_rdata),
    .mem_address_o (steer_address_d),
    .mem_be_o      (steer_be_d),
    .mem_wdata_o   (steer_wdata_d),
    .rdata_o       (steer_rdata_d)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      req_ready_q   <= 1'b1;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      rdata_q       <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_be_q      <= '0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      lat_byte_q    <= 1'b0;
      lat_lane_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_read || req_write) begin
            mem_write_q   <= req_write;
            mem_read_q    <= !req_write;
            mem_address_q <= steer_address_d;
            mem_be_q      <= steer_be_d;
            mem_wdata_q   <= steer_wdata_d;
            lat_byte_q    <= req_byte;
            lat_lane_q    <= req_addr[0];
            cnt_q         <= '0;
            req_ready_q   <= 1'b0;
            state_q       <= BUSY;
          end
        end
        BUSY: begin
          // Strobes drop on the resp edge itself; the memory would otherwise restart.
          if (mem_resp) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (mem_read_q) rdata_q <= steer_rdata_d;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end else if (TIMEOUT_EN && cnt_q == CNT_LAST) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            done_q      <= 1'b1;
            err_q       <= 1'b1;
            state_q     <= DONE;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready       = req_ready_q;
  assign done            = done_q;
  assign err             = err_q;
  assign rdata_out       = rdata_q;
  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_byte_enable = mem_be_q;
  assign mem_address     = mem_address_q;
  assign mem_wdata       = mem_wdata_q;

endmodule
